lif_seq_neuron: RTL and testbench

//  Next-generation LIF neuron stage that sits behind accumulator_correction in the TPPE datapath.

---
 rtl/tppe_pkg.sv | 28 ++
 rtl/lif_update_unit.sv | 37 +++
 rtl/lif_seq_neuron.sv | 134 +++++++++++++
 tb/tb_lif_seq_neuron.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tppe_pkg.sv
// Shared types and helpers for the TPPE LIF neuron stage.
package tppe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } lif_state_e;

   localparam logic RST_SOFT = 1'b0;
   localparam logic RST_HARD = 1'b1;

   // Clamp a sign-extended sum into a signed range of 'width' bits.
   function automatic logic signed [31:0] sat_mem(input logic signed [31:0] s, input int width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (s > hi) begin
         return hi;
      end
      if (s < lo) begin
         return lo;
      end
      return s;
   endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-timestep LIF update: leak, integrate, saturate, fire and reset.
module lif_update_unit
   import tppe_pkg::*;
#(
   parameter int Q          = 10,
   parameter int MEM_WIDTH  = 14,
   parameter int LEAK_SHIFT = 4
) (
   input  logic signed [MEM_WIDTH-1:0] v,
   input  logic signed [Q-1:0]         x,
   input  logic [MEM_WIDTH-2:0]        thr,
   input  logic                        mode,
   output logic signed [MEM_WIDTH-1:0] v_next,
   output logic                        spike
);

   logic signed [31:0] v_w;
   logic signed [31:0] x_w;
   logic signed [31:0] leak_w;
   logic signed [31:0] thr_w;
   logic signed [31:0] sat_w;

   // The sum is formed wide enough that it can never wrap before the clamp.
   always_comb begin
      v_w    = {{(32-MEM_WIDTH){v[MEM_WIDTH-1]}}, v};
      x_w    = {{(32-Q){x[Q-1]}}, x};
      leak_w = (LEAK_SHIFT != 0) ? (v_w >>> LEAK_SHIFT) : 32'sd0;
      thr_w  = {{(33-MEM_WIDTH){1'b0}}, thr};
      sat_w  = sat_mem(v_w - leak_w + x_w, MEM_WIDTH);
      spike  = (sat_w >= thr_w);
      v_next = MEM_WIDTH'(sat_w);
      if (spike) begin
         v_next = (mode == RST_HARD) ? '0 : MEM_WIDTH'(sat_w - thr_w);
      end
   end

endmodule

// File: rtl/lif_seq_neuron.sv
// Sequential LIF neuron: accepts a packed batch of T currents, integrates one step per clock,
// and returns spike train, spike count and final membrane potential on an output handshake.
module lif_seq_neuron
   import tppe_pkg::*;
#(
   parameter int T          = 16,
   parameter int Q          = 10,
   parameter int MEM_WIDTH  = 14,
   parameter int LEAK_SHIFT = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [T*Q-1:0]               in_data,
   input  logic [MEM_WIDTH-2:0]         threshold,
   input  logic                         hard_reset_mode,
   input  logic                         keep_vmem,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [T-1:0]                 spike_out,
   output logic [$clog2(T+1)-1:0]       spike_count,
   output logic signed [MEM_WIDTH-1:0]  vmem_out
);

   localparam int CW = $clog2(T + 1);
   localparam int TW = $clog2(T + 1);
   localparam logic [TW-1:0] T_END = TW'(T);

   lif_state_e state_reg, state_next;

   logic [TW-1:0]               t_reg;
   logic [T*Q-1:0]              data_reg;
   logic [MEM_WIDTH-2:0]        thr_reg;
   logic                        hard_reg;
   logic signed [MEM_WIDTH-1:0] v_reg;
   logic signed [MEM_WIDTH-1:0] vret_reg;
   logic [T-1:0]                spike_sh_reg;
   logic [T-1:0]                spike_out_reg;
   logic [CW-1:0]               count_reg;
   logic signed [MEM_WIDTH-1:0] vmem_out_reg;

   logic signed [MEM_WIDTH-1:0] v_next;
   logic                        spike_now;
   logic [CW-1:0]               pop_sum [T+1];

   lif_update_unit #(
      .Q          (Q),
      .MEM_WIDTH  (MEM_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_update (
      .v      (v_reg),
      .x      (data_reg[Q-1:0]),
      .thr    (thr_reg),
      .mode   (hard_reg),
      .v_next (v_next),
      .spike  (spike_now)
   );

   assign pop_sum[0] = '0;
   for (genvar gi = 0; gi < T; gi++) begin : g_pop
      assign pop_sum[gi+1] = pop_sum[gi] + CW'(spike_sh_reg[gi]);
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (t_reg == T_END) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // RUN spends T cycles on updates and one final cycle publishing the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         t_reg         <= '0;
         data_reg      <= '0;
         thr_reg       <= '0;
         hard_reg      <= RST_SOFT;
         v_reg         <= '0;
         vret_reg      <= '0;
         spike_sh_reg  <= '0;
         spike_out_reg <= '0;
         count_reg     <= '0;
         vmem_out_reg  <= '0;
      end else begin
         state_reg <= state_next;
         unique case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg     <= in_data;
                  thr_reg      <= (threshold == '0) ? {{(MEM_WIDTH-2){1'b0}}, 1'b1} : threshold;
                  hard_reg     <= hard_reset_mode;
                  v_reg        <= keep_vmem ? vret_reg : '0;
                  t_reg        <= '0;
                  spike_sh_reg <= '0;
               end
            end
            RUN: begin
               if (t_reg == T_END) begin
                  spike_out_reg <= spike_sh_reg;
                  count_reg     <= pop_sum[T];
                  vmem_out_reg  <= v_reg;
                  vret_reg      <= v_reg;
               end else begin
                  v_reg        <= v_next;
                  spike_sh_reg <= {spike_now, spike_sh_reg[T-1:1]};
                  data_reg     <= data_reg >> Q;
                  t_reg        <= t_reg + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign spike_out   = spike_out_reg;
   assign spike_count = count_reg;
   assign vmem_out    = vmem_out_reg;

endmodule

// File: tb/tb_lif_seq_neuron.sv
// Directed self-checking bench for lif_seq_neuron (T=16, Q=10, MEM_WIDTH=14), with a leaky twin instance.
module tb_lif_seq_neuron;

   localparam int T  = 16;
   localparam int Q  = 10;
   localparam int MW = 14;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [T*Q-1:0]       in_data = '0;
   logic [MW-2:0]        threshold = '0;
   logic                 hard_reset_mode = 1'b0;
   logic                 keep_vmem = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [T-1:0]         spike_out;
   logic [4:0]           spike_count;
   logic signed [MW-1:0] vmem_out;

   logic                 lk_in_ready;
   logic                 lk_out_valid;
   logic [T-1:0]         lk_spike_out;
   logic [4:0]           lk_spike_count;
   logic signed [MW-1:0] lk_vmem_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lif_seq_neuron #(.T(T), .Q(Q), .MEM_WIDTH(MW), .LEAK_SHIFT(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .threshold(threshold), .hard_reset_mode(hard_reset_mode), .keep_vmem(keep_vmem),
      .out_valid(out_valid), .out_ready(out_ready), .spike_out(spike_out),
      .spike_count(spike_count), .vmem_out(vmem_out)
   );

   lif_seq_neuron #(.T(T), .Q(Q), .MEM_WIDTH(MW), .LEAK_SHIFT(4)) dut_leak (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lk_in_ready), .in_data(in_data),
      .threshold(threshold), .hard_reset_mode(hard_reset_mode), .keep_vmem(keep_vmem),
      .out_valid(lk_out_valid), .out_ready(out_ready), .spike_out(lk_spike_out),
      .spike_count(lk_spike_count), .vmem_out(lk_vmem_out)
   );

   task automatic set_inputs(input int xv, input int thr, input logic hard, input logic keep);
      logic [31:0] xv_l;
      logic [31:0] thr_l;
      xv_l  = xv;
      thr_l = thr;
      for (int k = 0; k < T; k++) in_data[k*Q +: Q] = xv_l[Q-1:0];
      threshold       = thr_l[MW-2:0];
      hard_reset_mode = hard;
      keep_vmem       = keep;
   endtask

   // Offers one batch at a negedge; the following posedge is the accepting edge.
   task automatic drive_batch(input int xv, input int thr, input logic hard, input logic keep);
      @(negedge clk);
      set_inputs(xv, thr, hard, keep);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || spike_out !== '0 || spike_count !== '0 || vmem_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b spikes=%h count=%0d vmem=%0d, want all 0",
                  out_valid, spike_out, spike_count, vmem_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_hard_mode();
      int lat;
      drive_batch(10, 31, 1'b1, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hard_busy: got in_ready=%b, want 0", in_ready);
      end
      wait_valid(lat);
      n_checks++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL hard_latency: got %0d cycles, want 17", lat);
      end
      n_checks++;
      if (spike_out !== 16'h8888 || spike_count !== 5'd4 || vmem_out !== 14'sd0) begin
         n_fail++;
         $display("FAIL hard_result: got spikes=%h count=%0d vmem=%0d, want 8888/4/0",
                  spike_out, spike_count, vmem_out);
      end
      release_result();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL hard_release: got out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      $display("test_hard_mode done: spikes=%h count=%0d vmem=%0d", spike_out, spike_count, vmem_out);
   endtask

   task automatic test_soft_mode();
      int lat;
      drive_batch(10, 31, 1'b0, 1'b0);
      wait_valid(lat);
      n_checks++;
      if (lat !== 17 || spike_out !== 16'h9248 || spike_count !== 5'd5 || vmem_out !== 14'sd5) begin
         n_fail++;
         $display("FAIL soft_result: got lat=%0d spikes=%h count=%0d vmem=%0d, want 17/9248/5/5",
                  lat, spike_out, spike_count, vmem_out);
      end
      n_checks++;
      if (lk_out_valid !== 1'b1 || lk_spike_out !== 16'h1248 || lk_spike_count !== 5'd4 ||
          lk_vmem_out !== 14'sd29) begin
         n_fail++;
         $display("FAIL soft_leak: got valid=%b spikes=%h count=%0d vmem=%0d, want 1/1248/4/29",
                  lk_out_valid, lk_spike_out, lk_spike_count, lk_vmem_out);
      end
      release_result();
      $display("test_soft_mode done: spikes=%h count=%0d vmem=%0d", spike_out, spike_count, vmem_out);
   endtask

   task automatic test_saturation();
      int lat;
      for (int b = 0; b < 2; b++) begin
         drive_batch(-512, 8191, 1'b0, (b == 1));
         wait_valid(lat);
         n_checks++;
         if (lat !== 17 || spike_out !== '0 || spike_count !== '0 || vmem_out !== 14'h2000) begin
            n_fail++;
            $display("FAIL saturation_b%0d: got lat=%0d spikes=%h count=%0d vmem=%0d, want 17/0/0/-8192",
                     b, lat, spike_out, spike_count, vmem_out);
         end
         release_result();
         $display("test_saturation batch %0d: vmem=%0d", b, vmem_out);
      end
   endtask

   task automatic test_threshold_zero();
      int lat;
      drive_batch(0, 0, 1'b1, 1'b0);
      wait_valid(lat);
      n_checks++;
      if (spike_out !== '0 || spike_count !== '0 || vmem_out !== 14'sd0) begin
         n_fail++;
         $display("FAIL thr_zero: got spikes=%h count=%0d vmem=%0d, want 0/0/0",
                  spike_out, spike_count, vmem_out);
      end
      release_result();
      $display("test_threshold_zero done: spikes=%h", spike_out);
   endtask

   task automatic test_back_to_back();
      int lat;
      drive_batch(10, 31, 1'b0, 1'b0);
      wait_valid(lat);
      @(negedge clk);
      set_inputs(10, 31, 1'b1, 1'b0);
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || spike_out !== 16'h9248 ||
             spike_count !== 5'd5 || vmem_out !== 14'sd5) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got valid=%b ready=%b spikes=%h count=%0d vmem=%0d, want 1/0/9248/5/5",
                     c, out_valid, in_ready, spike_out, spike_count, vmem_out);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept: got in_ready=%b, want 0", in_ready);
      end
      wait_valid(lat);
      n_checks++;
      if (lat !== 17 || spike_out !== 16'h8888 || spike_count !== 5'd4 || vmem_out !== 14'sd0) begin
         n_fail++;
         $display("FAIL bp_next: got lat=%0d spikes=%h count=%0d vmem=%0d, want 17/8888/4/0",
                  lat, spike_out, spike_count, vmem_out);
      end
      release_result();
      $display("test_back_to_back done: spikes=%h", spike_out);
   endtask

   task automatic test_abort();
      int lat;
      logic seen_valid;
      drive_batch(10, 31, 1'b0, 1'b0);
      wait_valid(lat);
      n_checks++;
      if (spike_out !== 16'h9248 || vmem_out !== 14'sd5) begin
         n_fail++;
         $display("FAIL abort_setup: got spikes=%h vmem=%0d, want 9248/5", spike_out, vmem_out);
      end
      release_result();
      drive_batch(10, 31, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_valid: got out_valid seen=%b, want 0", seen_valid);
      end
      drive_batch(10, 31, 1'b1, 1'b1);
      wait_valid(lat);
      n_checks++;
      if (lat !== 17 || spike_out !== 16'h8888 || spike_count !== 5'd4 || vmem_out !== 14'sd0) begin
         n_fail++;
         $display("FAIL abort_next: got lat=%0d spikes=%h count=%0d vmem=%0d, want 17/8888/4/0",
                  lat, spike_out, spike_count, vmem_out);
      end
      release_result();
      $display("test_abort done: spikes=%h vmem=%0d", spike_out, vmem_out);
   endtask

   initial begin
      test_reset();
      test_hard_mode();
      test_soft_mode();
      test_saturation();
      test_threshold_zero();
      test_back_to_back();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
